fifo_wr_ctrl: RTL and testbench
===============================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter RAM_ADDR_WIDTH, default 5: storage address width; DEPTH = 2^RAM_ADDR_WIDTH units.
REQ-002 Parameter WR_CNT_WIDTH, default RAM_ADDR_WIDTH+1: width of wr_data_count.
REQ-003 Parameter WR_IND, default 1: write-pointer increment per accepted write, power of two, at most DEPTH.
REQ-004 Parameter PROG_FULL_THRESH, default DEPTH-4: occupancy at or above which prog_full asserts.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 wr_clk  input  1  write clock; all state on its rising edge.
REQ-007 wr_rst  input  1  asynchronous, active-high reset.
REQ-008 wr_en  input  1  write request, high active.
REQ-009 rd_ptr_sync  input  RAM_ADDR_WIDTH+1  read pointer already synchronized into wr_clk domain, unsigned binary.
REQ-010 wr_ptr  output  RAM_ADDR_WIDTH+1  binary write pointer, registered.
REQ-011 wr_ptr_gray  output  RAM_ADDR_WIDTH+1  Gray-coded write pointer for CDC, registered.
REQ-012 ram_wr_en  output  1  qualified storage write enable.
REQ-013 fifo_full  output  1  full flag, combinational.
REQ-014 prog_full  output  1  programmable almost-full, registered.
REQ-015 wr_data_count  output  WR_CNT_WIDTH  occupancy seen from write side.
REQ-016 overflow  output  1  one-cycle pulse, write attempted while full.
REQ-017 ovf_sticky  output  1  sticky overflow; ovf_clr  input  1  synchronous clear of ovf_sticky.

Function
REQ-018 wr_ram_cnt SHALL equal (wr_ptr - rd_ptr_sync) modulo 2^(RAM_ADDR_WIDTH+1); MSB-differ case yields the wrapped difference, never negative.
REQ-019 wr_data_count SHALL equal the upper WR_CNT_WIDTH bits of wr_ram_cnt (bits [RAM_ADDR_WIDTH : RAM_ADDR_WIDTH+1-WR_CNT_WIDTH]).
REQ-020 fifo_full SHALL be 1 exactly when wr_ram_cnt > DEPTH - WR_IND (free space below one write).
REQ-021 ram_wr_en SHALL equal wr_en AND NOT fifo_full, same cycle, zero latency.
REQ-022 When ram_wr_en is 1, wr_ptr SHALL advance by WR_IND at the next edge, wrapping modulo 2^(RAM_ADDR_WIDTH+1); otherwise hold.
REQ-023 wr_ptr_gray SHALL equal bin2gray of wr_ptr in every cycle (registered from the next-pointer value, not from wr_ptr), so only one bit changes per WR_IND=1 step.
REQ-024 prog_full SHALL register (wr_ram_cnt >= PROG_FULL_THRESH), one cycle latency.
REQ-025 overflow SHALL pulse high for one cycle, one cycle after any cycle with wr_en=1 and fifo_full=1; wr_ptr unchanged.
REQ-026 ovf_sticky SHALL set on the same edge as overflow sets, clear on ovf_clr; simultaneous set and clear: set wins.
REQ-027 Read pointer advance (rd_ptr_sync change) and write in the same cycle SHALL both take effect; fifo_full reflects the new rd_ptr_sync immediately.

Reset
REQ-028 While wr_rst=1: wr_ptr=0, wr_ptr_gray=0, prog_full=0, overflow=0, ovf_sticky=0, asynchronously.
REQ-029 Combinational outputs SHALL follow from reset register values and rd_ptr_sync (rd_ptr_sync=0 gives fifo_full=0, wr_data_count=0).
REQ-030 wr_rst asserted mid-stream SHALL discard pending write; ram_wr_en during reset is don't-care for storage, pointer stays 0.

Configuration
REQ-031 Macro FIFO_WR_OVERFLOW_EN: defined -> overflow, ovf_sticky, ovf_clr logic per REQ-025/026; undefined -> ports kept, overflow and ovf_sticky tied 0, ovf_clr ignored, no registers inferred.

Structure
REQ-032 Shared package fifo_pkg SHALL hold bin2gray function, DEPTH derivation, and pointer-width constants, shared with the read controller.
REQ-033 One sub-module fifo_bin2gray (parameterized width, combinational) SHALL be instantiated for the Gray encoding.

Verification (defaults, DEPTH=32)
REQ-034 Reset, rd_ptr_sync=0, 32 writes -> wr_ptr 0..32, fifo_full=1 after 32nd, wr_data_count=32, ram_wr_en=0 on 33rd.
REQ-035 Full, rd_ptr_sync 0->4 with wr_en=1 same cycle -> fifo_full drops, write accepted, wr_ptr=33.
REQ-036 Drive wrap: wr_ptr 63->0, rd_ptr_sync=60 -> wr_data_count=4, wr_ptr_gray steps 100000->000000 with one-bit change.
REQ-037 PROG_FULL_THRESH=28, fill to 28 -> prog_full rises one cycle after count reaches 28.
REQ-038 With FIFO_WR_OVERFLOW_EN, wr_en while full -> overflow one-cycle pulse, ovf_sticky=1; ovf_clr with coincident overflow -> ovf_sticky stays 1; without macro both stay 0.
REQ-039 wr_rst pulsed mid-fill at count 17 -> all registered outputs 0 immediately, before next clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth and pointer-width derivation plus the
// binary-to-Gray helper, used by both the write and the read controller.
package fifo_pkg;

  localparam int DEFAULT_RAM_ADDR_WIDTH = 5;
  localparam int MAX_PTR_WIDTH          = 32;

  // Number of storage units addressed by an address of the given width.
  function automatic int fifo_depth(input int addrWidth);
    return 1 << addrWidth;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int addrWidth);
    return addrWidth + 1;
  endfunction

  // Reflected binary Gray code of a pointer value.
  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_bin2gray.sv
// Purely combinational binary-to-Gray encoder of configurable width.
module fifo_bin2gray #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // Each Gray bit is the XOR of a binary bit and its upper neighbour.
  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: write pointer (binary and
// Gray), full / programmable-full flags and write-side occupancy.
// Optional feature macro: FIFO_WR_OVERFLOW_EN enables the overflow pulse and
// the sticky overflow flag; without it those outputs are constant 0.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH   = DEFAULT_RAM_ADDR_WIDTH,
  parameter int WR_CNT_WIDTH     = RAM_ADDR_WIDTH + 1,
  parameter int WR_IND           = 1,
  parameter int PROG_FULL_THRESH = fifo_depth(RAM_ADDR_WIDTH) - 4
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic                      wr_en,
  input  logic [RAM_ADDR_WIDTH:0]   rd_ptr_sync,
  input  logic                      ovf_clr,
  output logic [RAM_ADDR_WIDTH:0]   wr_ptr,
  output logic [RAM_ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                      ram_wr_en,
  output logic                      fifo_full,
  output logic                      prog_full,
  output logic [WR_CNT_WIDTH-1:0]   wr_data_count,
  output logic                      overflow,
  output logic                      ovf_sticky
);

  localparam int PTR_WIDTH = ptr_width(RAM_ADDR_WIDTH);
  localparam int DEPTH     = fifo_depth(RAM_ADDR_WIDTH);

  localparam logic [PTR_WIDTH-1:0] FULL_LIMIT = PTR_WIDTH'(DEPTH - WR_IND);
  localparam logic [PTR_WIDTH-1:0] PROG_LIMIT = PTR_WIDTH'(PROG_FULL_THRESH);
  localparam logic [PTR_WIDTH-1:0] PTR_STEP   = PTR_WIDTH'(WR_IND);

  logic [PTR_WIDTH-1:0] wrPtr_q;
  logic [PTR_WIDTH-1:0] wrPtr_d;
  logic [PTR_WIDTH-1:0] wrPtrGray_q;
  logic [PTR_WIDTH-1:0] wrPtrGray_d;
  logic [PTR_WIDTH-1:0] wrRamCnt;
  logic                 progFull_q;
  logic                 fullNow;
  logic                 ramWrEn;

  // Occupancy is the modular pointer distance, so a wrapped write pointer
  // still yields a small positive count.
  assign wrRamCnt = wrPtr_q - rd_ptr_sync;

  // Full as soon as one more write of WR_IND units would not fit; this looks
  // at the live read pointer so a same-cycle read frees space immediately.
  assign fullNow  = wrRamCnt > FULL_LIMIT;
  assign ramWrEn  = wr_en & ~fullNow;
  assign wrPtr_d  = ramWrEn ? wrPtr_q + PTR_STEP : wrPtr_q;

  // The Gray pointer is encoded from the next binary value so it is
  // registered in step with wr_ptr rather than lagging by a cycle.
  fifo_bin2gray #(
    .WIDTH (PTR_WIDTH)
  ) u_bin2gray (
    .bin_i  (wrPtr_d),
    .gray_o (wrPtrGray_d)
  );

  // Pointer and almost-full state; prog_full deliberately sees the current
  // occupancy and presents it one cycle later.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wrPtr_q     <= '0;
      wrPtrGray_q <= '0;
      progFull_q  <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      wrPtrGray_q <= wrPtrGray_d;
      progFull_q  <= (wrRamCnt >= PROG_LIMIT);
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  logic overflow_q;
  logic ovfSticky_q;
  logic ovfEvent;

  assign ovfEvent = wr_en & fullNow;

  // A rejected write produces a one-cycle pulse and latches the sticky flag;
  // a new overflow outranks a clear arriving in the same cycle.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      overflow_q  <= 1'b0;
      ovfSticky_q <= 1'b0;
    end else begin
      overflow_q <= ovfEvent;
      if (ovfEvent) begin
        ovfSticky_q <= 1'b1;
      end else if (ovf_clr) begin
        ovfSticky_q <= 1'b0;
      end
    end
  end

  assign overflow   = overflow_q;
  assign ovf_sticky = ovfSticky_q;
`else
  logic ovfClr_unused;

  // Overflow reporting is compiled out: the ports stay, the flags read 0
  // and the clear input has nothing to act on.
  assign ovfClr_unused = ovf_clr;
  assign overflow      = 1'b0;
  assign ovf_sticky    = 1'b0;
`endif

  assign wr_ptr        = wrPtr_q;
  assign wr_ptr_gray   = wrPtrGray_q;
  assign prog_full     = progFull_q;
  assign ram_wr_en     = ramWrEn;
  assign fifo_full     = fullNow;
  assign wr_data_count = wrRamCnt[RAM_ADDR_WIDTH -: WR_CNT_WIDTH];

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl at default parameters (DEPTH=32).
// Expectations come from an occupancy-based model of the FIFO; overflow
// expectations follow FIFO_WR_OVERFLOW_EN as compiled.
module tb_fifo_wr_ctrl;

  logic       wr_clk;
  logic       wr_rst;
  logic       wr_en;
  logic [5:0] rd_ptr_sync;
  logic       ovf_clr;
  logic [5:0] wr_ptr;
  logic [5:0] wr_ptr_gray;
  logic       ram_wr_en;
  logic       fifo_full;
  logic       prog_full;
  logic [5:0] wr_data_count;
  logic       overflow;
  logic       ovf_sticky;

  int checks;
  int failures;

  int mPtr;
  bit mProg;
  bit mOvf;
  bit mSticky;
  bit curWe;
  bit curClr;
  int curRd;

  fifo_wr_ctrl dut (
    .wr_clk        (wr_clk),
    .wr_rst        (wr_rst),
    .wr_en         (wr_en),
    .rd_ptr_sync   (rd_ptr_sync),
    .ovf_clr       (ovf_clr),
    .wr_ptr        (wr_ptr),
    .wr_ptr_gray   (wr_ptr_gray),
    .ram_wr_en     (ram_wr_en),
    .fifo_full     (fifo_full),
    .prog_full     (prog_full),
    .wr_data_count (wr_data_count),
    .overflow      (overflow),
    .ovf_sticky    (ovf_sticky)
  );

  // Free-running write clock, rising edges at 5, 15, 25, ...
  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  // Occupancy as the FIFO would count it: units written minus units read.
  function automatic int mCount();
    return (mPtr - curRd) & 63;
  endfunction

  function automatic bit mFull();
    return mCount() > 31;
  endfunction

  function automatic bit mAccept();
    return curWe && !mFull();
  endfunction

  function automatic logic [5:0] mGray();
    int g;
    g = mPtr ^ (mPtr >> 1);
    return 6'(g);
  endfunction

  // Present a new set of inputs and let combinational outputs settle.
  task automatic applyStimulus(input bit we, input int rd, input bit clr);
    curWe       = we;
    curRd       = rd & 63;
    curClr      = clr;
    wr_en       = we;
    rd_ptr_sync = 6'(curRd);
    ovf_clr     = clr;
    #1;
  endtask

  // Advance one clock and update the model from the inputs of that cycle.
  task automatic tick();
    int cnt;
    bit full;
    bit acc;
    cnt  = mCount();
    full = mFull();
    acc  = mAccept();
    @(posedge wr_clk);
    #1;
    mPtr  = (mPtr + (acc ? 1 : 0)) & 63;
    mProg = (cnt >= 28);
`ifdef FIFO_WR_OVERFLOW_EN
    mOvf = curWe && full;
    if (curWe && full) mSticky = 1'b1;
    else if (curClr) mSticky = 1'b0;
`endif
  endtask

  task automatic test_reset();
    wr_rst = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    #10;
    checks++; if (wr_ptr !== 6'd0) begin failures++; $display("[TB] FAIL reset_wr_ptr got=%0d exp=0", wr_ptr); end
    checks++; if (wr_ptr_gray !== 6'd0) begin failures++; $display("[TB] FAIL reset_gray got=%b exp=000000", wr_ptr_gray); end
    checks++; if (prog_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_prog_full got=%b exp=0", prog_full); end
    checks++; if (overflow !== 1'b0 || ovf_sticky !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b%b exp=00", overflow, ovf_sticky); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (wr_data_count !== 6'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", wr_data_count); end
    wr_rst = 1'b0;
    mPtr = 0; mProg = 0; mOvf = 0; mSticky = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 0, 1'b0);
      checks++; if (ram_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL fill_wr_en[%0d] got=%b exp=1", i, ram_wr_en); end
      tick();
      checks++; if (wr_ptr !== 6'(i + 1)) begin failures++; $display("[TB] FAIL fill_ptr[%0d] got=%0d exp=%0d", i, wr_ptr, i + 1); end
      checks++; if (wr_ptr_gray !== mGray()) begin failures++; $display("[TB] FAIL fill_gray[%0d] got=%b exp=%b", i, wr_ptr_gray, mGray()); end
      checks++; if (prog_full !== mProg) begin failures++; $display("[TB] FAIL fill_prog_full[%0d] got=%b exp=%b", i, prog_full, mProg); end
      if (i == 27) begin
        checks++; if (prog_full !== 1'b0) begin failures++; $display("[TB] FAIL prog_full_early got=%b exp=0", prog_full); end
      end
      if (i == 28) begin
        checks++; if (prog_full !== 1'b1) begin failures++; $display("[TB] FAIL prog_full_rise got=%b exp=1", prog_full); end
      end
    end
    applyStimulus(1'b1, 0, 1'b0);
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full got=%b exp=1", fifo_full); end
    checks++; if (wr_data_count !== 6'd32) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=32", wr_data_count); end
    checks++; if (ram_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL fill_33rd_wr_en got=%b exp=0", ram_wr_en); end
    tick();
    checks++; if (wr_ptr !== 6'd32) begin failures++; $display("[TB] FAIL fill_33rd_ptr got=%0d exp=32", wr_ptr); end
    checks++; if (overflow !== mOvf) begin failures++; $display("[TB] FAIL fill_overflow got=%b exp=%b", overflow, mOvf); end
    applyStimulus(1'b0, 0, 1'b1);
    tick();
  endtask

  task automatic test_read_write_same_cycle();
    applyStimulus(1'b1, 4, 1'b0);
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("[TB] FAIL rw_full got=%b exp=0", fifo_full); end
    checks++; if (ram_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL rw_wr_en got=%b exp=1", ram_wr_en); end
    tick();
    checks++; if (wr_ptr !== 6'd33) begin failures++; $display("[TB] FAIL rw_ptr got=%0d exp=33", wr_ptr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 4, 1'b0);
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("[TB] FAIL ovf_full got=%b exp=1", fifo_full); end
    tick();
    checks++; if (overflow !== mOvf) begin failures++; $display("[TB] FAIL ovf_pulse got=%b exp=%b", overflow, mOvf); end
    checks++; if (ovf_sticky !== mSticky) begin failures++; $display("[TB] FAIL ovf_sticky_set got=%b exp=%b", ovf_sticky, mSticky); end
    checks++; if (wr_ptr !== 6'd36) begin failures++; $display("[TB] FAIL ovf_ptr_hold got=%0d exp=36", wr_ptr); end
    applyStimulus(1'b0, 4, 1'b0);
    tick();
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_pulse_end got=%b exp=0", overflow); end
    checks++; if (ovf_sticky !== mSticky) begin failures++; $display("[TB] FAIL ovf_sticky_hold got=%b exp=%b", ovf_sticky, mSticky); end
    applyStimulus(1'b1, 4, 1'b1);
    tick();
    checks++; if (ovf_sticky !== mSticky) begin failures++; $display("[TB] FAIL ovf_set_wins got=%b exp=%b", ovf_sticky, mSticky); end
    applyStimulus(1'b0, 4, 1'b1);
    tick();
    checks++; if (ovf_sticky !== 1'b0 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%b%b exp=00", overflow, ovf_sticky); end
  endtask

  task automatic test_wrap();
    logic [5:0] prevGray;
    for (int i = 0; i < 27; i++) begin
      applyStimulus(1'b1, 36, 1'b0);
      tick();
    end
    checks++; if (wr_ptr !== 6'd63) begin failures++; $display("[TB] FAIL wrap_pre_ptr got=%0d exp=63", wr_ptr); end
    applyStimulus(1'b1, 60, 1'b0);
    checks++; if (wr_data_count !== 6'd3) begin failures++; $display("[TB] FAIL wrap_pre_count got=%0d exp=3", wr_data_count); end
    prevGray = wr_ptr_gray;
    tick();
    checks++; if (wr_ptr !== 6'd0) begin failures++; $display("[TB] FAIL wrap_ptr got=%0d exp=0", wr_ptr); end
    checks++; if (wr_data_count !== 6'd4) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=4", wr_data_count); end
    checks++; if (prevGray !== 6'b100000 || wr_ptr_gray !== 6'b000000) begin failures++; $display("[TB] FAIL wrap_gray got=%b->%b exp=100000->000000", prevGray, wr_ptr_gray); end
    checks++; if ($countones(prevGray ^ wr_ptr_gray) != 1) begin failures++; $display("[TB] FAIL wrap_gray_onebit got=%0d exp=1", $countones(prevGray ^ wr_ptr_gray)); end
  endtask

  task automatic test_random();
    int cnt;
    int adv;
    bit we;
    bit clr;
    for (int i = 0; i < 400; i++) begin
      cnt = mCount();
      adv = ($urandom_range(3, 0) == 0) ? int'($urandom_range(cnt, 0)) : 0;
      we  = ($urandom_range(99, 0) < 70);
      clr = ($urandom_range(9, 0) == 0);
      applyStimulus(we, curRd + adv, clr);
      checks++; if (fifo_full !== mFull()) begin failures++; $display("[TB] FAIL rnd_full[%0d] got=%b exp=%b", i, fifo_full, mFull()); end
      checks++; if (ram_wr_en !== mAccept()) begin failures++; $display("[TB] FAIL rnd_wr_en[%0d] got=%b exp=%b", i, ram_wr_en, mAccept()); end
      checks++; if (wr_data_count !== 6'(mCount())) begin failures++; $display("[TB] FAIL rnd_count[%0d] got=%0d exp=%0d", i, wr_data_count, mCount()); end
      tick();
      checks++; if (wr_ptr !== 6'(mPtr)) begin failures++; $display("[TB] FAIL rnd_ptr[%0d] got=%0d exp=%0d", i, wr_ptr, mPtr); end
      checks++; if (wr_ptr_gray !== mGray()) begin failures++; $display("[TB] FAIL rnd_gray[%0d] got=%b exp=%b", i, wr_ptr_gray, mGray()); end
      checks++; if (prog_full !== mProg) begin failures++; $display("[TB] FAIL rnd_prog_full[%0d] got=%b exp=%b", i, prog_full, mProg); end
      checks++; if (overflow !== mOvf || ovf_sticky !== mSticky) begin failures++; $display("[TB] FAIL rnd_ovf[%0d] got=%b%b exp=%b%b", i, overflow, ovf_sticky, mOvf, mSticky); end
    end
  endtask

  task automatic test_reset_midstream();
    int base;
    base = mPtr;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, base, 1'b0);
      tick();
    end
    checks++; if (wr_data_count !== 6'd17) begin failures++; $display("[TB] FAIL mid_count got=%0d exp=17", wr_data_count); end
    applyStimulus(1'b1, base, 1'b0);
    wr_rst = 1'b1;
    #1;
    mPtr = 0; mProg = 0; mOvf = 0; mSticky = 0;
    checks++; if (wr_ptr !== 6'd0 || wr_ptr_gray !== 6'd0) begin failures++; $display("[TB] FAIL mid_reset_ptr got=%0d/%b exp=0/000000", wr_ptr, wr_ptr_gray); end
    checks++; if (prog_full !== 1'b0 || overflow !== 1'b0 || ovf_sticky !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_flags got=%b%b%b exp=000", prog_full, overflow, ovf_sticky); end
    checks++; if (wr_data_count !== 6'(mCount())) begin failures++; $display("[TB] FAIL mid_reset_count got=%0d exp=%0d", wr_data_count, mCount()); end
    @(posedge wr_clk);
    #1;
    checks++; if (wr_ptr !== 6'd0) begin failures++; $display("[TB] FAIL mid_reset_hold got=%0d exp=0", wr_ptr); end
    wr_rst = 1'b0;
    applyStimulus(1'b1, 0, 1'b0);
    tick();
    checks++; if (wr_ptr !== 6'(mPtr)) begin failures++; $display("[TB] FAIL post_reset_ptr got=%0d exp=%0d", wr_ptr, mPtr); end
  endtask

  // Scenario sequence and final verdict.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_read_write_same_cycle();
    test_overflow();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
